// File: rtl/m_stopwatch_core_if.sv
// -----------------------------------------------------------------------------
// m_stopwatch_core_if
//   Signal bundle between the stopwatch core and its surroundings: the 10 ms
//   timebase, the debounced control pulses and the BCD MM:SS.cc count.
//
//   Signals
//     clk10ms     10 ms timebase level, synchronous to clk
//     start_stop  one-cycle pulse: toggle RUN/STOP
//     clear       one-cycle pulse: zero the count (honoured in STOP only)
//     running     1 while the core is in RUN
//     cs_ones     centiseconds units, BCD 0..9
//     cs_tens     centiseconds tens,  BCD 0..9
//     sec_ones    seconds units,      BCD 0..9
//     sec_tens    seconds tens,       BCD 0..5
//     min_ones    minutes units,      BCD 0..9
//     min_tens    minutes tens,       BCD 0..9
//     wrap        one-cycle pulse when the count rolls over to 00:00.00
//
//   Modports
//     master  the controlling side (timebase, buttons, display)
//     slave   the stopwatch core
// -----------------------------------------------------------------------------
interface m_stopwatch_core_if;

    logic       clk10ms;
    logic       start_stop;
    logic       clear;
    logic       running;
    logic [3:0] cs_ones;
    logic [3:0] cs_tens;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       wrap;

    modport master (
        output clk10ms,
        output start_stop,
        output clear,
        input  running,
        input  cs_ones,
        input  cs_tens,
        input  sec_ones,
        input  sec_tens,
        input  min_ones,
        input  min_tens,
        input  wrap
    );

    modport slave (
        input  clk10ms,
        input  start_stop,
        input  clear,
        output running,
        output cs_ones,
        output cs_tens,
        output sec_ones,
        output sec_tens,
        output min_ones,
        output min_tens,
        output wrap
    );

endinterface : m_stopwatch_core_if

// File: rtl/m_stopwatch_core.sv
// -----------------------------------------------------------------------------
// m_stopwatch_core
//   Consumer end of the 10 ms timebase. Samples clk10ms, turns each rising
//   edge into a one-cycle tick and accumulates ticks into a BCD MM:SS.cc count
//   under start/stop/clear control. Feeds the 7-segment display driver.
//
//   Parameters
//     P_MIN_MAX   highest minute value before the count wraps to 00:00.00
//                 (legal 1..99)
//
//   Ports
//     clk         system clock
//     rst         asynchronous reset, active-low
//     sw          m_stopwatch_core_if.slave
//                   in : clk10ms, start_stop, clear
//                   out: running, cs_ones, cs_tens, sec_ones, sec_tens,
//                        min_ones, min_tens, wrap (all registered)
// -----------------------------------------------------------------------------
module m_stopwatch_core #(
    parameter int unsigned P_MIN_MAX = 59
) (
    input  logic               clk,
    input  logic               rst,
    m_stopwatch_core_if.slave  sw
);

    localparam logic [6:0] MIN_MAX = 7'(P_MIN_MAX);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [3:0] min_tens;
        logic [3:0] min_ones;
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
        logic [3:0] cs_tens;
        logic [3:0] cs_ones;
    } count_t;

    localparam count_t COUNT_ZERO = '0;

    state_t state;
    logic   running_q;
    logic   wrap_q;
    logic   clk10ms_d;
    count_t count_q;
    count_t count_nxt;
    logic   at_max;
    logic   tick;
    logic [6:0] minutes;

    // A level held high produces a single tick; the delay register clears on
    // reset, so a high timebase at reset release yields one tick.
    assign tick = sw.clk10ms & ~clk10ms_d;

    // Minutes are compared as a binary value so any P_MIN_MAX in 1..99 works.
    assign minutes = {3'b000, count_q.min_tens} * 7'd10 + {3'b000, count_q.min_ones};

    assign at_max = (minutes == MIN_MAX)         &&
                    (count_q.sec_tens == 4'd5)   &&
                    (count_q.sec_ones == 4'd9)   &&
                    (count_q.cs_tens  == 4'd9)   &&
                    (count_q.cs_ones  == 4'd9);

    // -------------------------------------------------------------------------
    // BCD incrementer: the count one centisecond later, with ripple carry from
    // the lowest digit upward and a rollover to zero at the configured maximum.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and a latch is never inferred.
        count_nxt = count_q;
        if (at_max) begin
            count_nxt = COUNT_ZERO;
        end else if (count_q.cs_ones != 4'd9) begin
            count_nxt.cs_ones = count_q.cs_ones + 4'd1;
        end else begin
            count_nxt.cs_ones = 4'd0;
            if (count_q.cs_tens != 4'd9) begin
                count_nxt.cs_tens = count_q.cs_tens + 4'd1;
            end else begin
                count_nxt.cs_tens = 4'd0;
                if (count_q.sec_ones != 4'd9) begin
                    count_nxt.sec_ones = count_q.sec_ones + 4'd1;
                end else begin
                    count_nxt.sec_ones = 4'd0;
                    if (count_q.sec_tens != 4'd5) begin
                        count_nxt.sec_tens = count_q.sec_tens + 4'd1;
                    end else begin
                        count_nxt.sec_tens = 4'd0;
                        if (count_q.min_ones != 4'd9) begin
                            count_nxt.min_ones = count_q.min_ones + 4'd1;
                        end else begin
                            count_nxt.min_ones = 4'd0;
                            // 99 minutes can only be reached with P_MIN_MAX=99,
                            // where at_max already handles the rollover.
                            count_nxt.min_tens = (count_q.min_tens == 4'd9) ?
                                                 4'd0 : count_q.min_tens + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs. In STOP, clear has priority over
    // start_stop. In RUN, a tick on the same cycle as start_stop is still
    // counted before the FSM falls back to STOP; clear is ignored.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_STOP;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
            clk10ms_d <= 1'b0;
            count_q   <= COUNT_ZERO;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples its inputs as they were before this edge.
            clk10ms_d <= sw.clk10ms;
            wrap_q    <= 1'b0;
            unique case (state)
                ST_STOP: begin
                    if (sw.clear) begin
                        count_q <= COUNT_ZERO;
                    end else if (sw.start_stop) begin
                        state     <= ST_RUN;
                        running_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        count_q <= count_nxt;
                        wrap_q  <= at_max;
                    end
                    if (sw.start_stop) begin
                        state     <= ST_STOP;
                        running_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_STOP;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign sw.running  = running_q;
    assign sw.wrap     = wrap_q;
    assign sw.cs_ones  = count_q.cs_ones;
    assign sw.cs_tens  = count_q.cs_tens;
    assign sw.sec_ones = count_q.sec_ones;
    assign sw.sec_tens = count_q.sec_tens;
    assign sw.min_ones = count_q.min_ones;
    assign sw.min_tens = count_q.min_tens;

endmodule : m_stopwatch_core

// File: tb/tb_m_stopwatch_core.sv
// -----------------------------------------------------------------------------
// tb_m_stopwatch_core
//   Self-checking bench for m_stopwatch_core. A reference model keeps the
//   elapsed time as a plain integer number of centiseconds and derives the
//   expected BCD digits from it by division; directed scenarios add fixed
//   expected values for reset, counting, stop/clear, simultaneous events,
//   held timebase, asynchronous reset and wrap. Uses P_MIN_MAX=1 so the wrap
//   point (01:59.99) is reachable in a short run.
// -----------------------------------------------------------------------------
module tb_m_stopwatch_core;

    localparam int unsigned MIN_MAX = 1;
    localparam int          MAX_CS  = (MIN_MAX * 60 + 59) * 100 + 99;

    logic clk = 1'b0;
    logic rst = 1'b1;

    m_stopwatch_core_if sw ();

    m_stopwatch_core #(.P_MIN_MAX(MIN_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (centisecond integer) -----------------
    int   m_cnt  = 0;
    logic m_run  = 1'b0;
    logic m_wrap = 1'b0;
    logic m_prev = 1'b0;
    wire  m_tick = sw.clk10ms & ~m_prev;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt  <= 0;
            m_run  <= 1'b0;
            m_wrap <= 1'b0;
            m_prev <= 1'b0;
        end else begin
            m_prev <= sw.clk10ms;
            m_wrap <= 1'b0;
            if (m_run) begin
                if (m_tick) begin
                    m_cnt  <= (m_cnt == MAX_CS) ? 0 : m_cnt + 1;
                    m_wrap <= (m_cnt == MAX_CS);
                end
                if (sw.start_stop) m_run <= 1'b0;
            end else begin
                if (sw.clear)           m_cnt <= 0;
                else if (sw.start_stop) m_run <= 1'b1;
            end
        end
    end

    function automatic logic [23:0] to_bcd(input int cs_total);
        int mins, secs, cs;
        mins = cs_total / 6000;
        secs = (cs_total / 100) % 60;
        cs   = cs_total % 100;
        return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10),
                4'(cs / 10), 4'(cs % 10)};
    endfunction

    wire [23:0] digits = {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones,
                          sw.cs_tens, sw.cs_ones};

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (mon_en)
            check("mon", {6'd0, sw.running, sw.wrap, digits},
                  {6'd0, m_run, m_wrap, to_bcd(m_cnt)});
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_ss();
        sw.start_stop = 1'b1;
        step();
        sw.start_stop = 1'b0;
    endtask

    task automatic pulse_clear();
        sw.clear = 1'b1;
        step();
        sw.clear = 1'b0;
    endtask

    task automatic tick_edge(input int gap);
        sw.clk10ms = 1'b1;
        step();
        sw.clk10ms = 1'b0;
        repeat (gap) step();
    endtask

    initial begin
        sw.clk10ms    = 1'b0;
        sw.start_stop = 1'b0;
        sw.clear      = 1'b0;
        #1 rst = 1'b0;
        mon_en = 1'b1;

        // 1: reset with the timebase toggling
        repeat (10) begin
            sw.clk10ms = ~sw.clk10ms;
            step();
        end
        check("rst_digits",  {8'd0, digits}, 32'd0);
        check("rst_running", {31'd0, sw.running}, 32'd0);
        check("rst_wrap",    {31'd0, sw.wrap}, 32'd0);
        sw.clk10ms = 1'b0;
        rst = 1'b1;
        step();

        // 2: basic count with one-cycle update latency
        pulse_ss();
        check("run_on", {31'd0, sw.running}, 32'd1);
        sw.clk10ms = 1'b1;
        #2 check("lat_pre", {8'd0, digits}, 32'h000000);
        step();
        check("lat_post", {8'd0, digits}, 32'h000001);
        sw.clk10ms = 1'b0;
        step();
        repeat (149) tick_edge($urandom_range(1, 3));
        check("count150", {8'd0, digits}, 32'h000150);
        check("count150_run", {31'd0, sw.running}, 32'd1);

        // 3: stop, clear, hold, clear ignored in RUN
        pulse_ss();
        check("stop_hold", {8'd0, digits}, 32'h000150);
        pulse_clear();
        check("clear0", {8'd0, digits}, 32'h000000);
        pulse_ss();
        repeat (37) tick_edge($urandom_range(1, 3));
        pulse_ss();
        repeat (20) tick_edge($urandom_range(1, 3));
        check("held37", {8'd0, digits}, 32'h000037);
        check("held37_run", {31'd0, sw.running}, 32'd0);
        pulse_clear();
        check("clear37", {8'd0, digits}, 32'h000000);
        pulse_ss();
        repeat (5) tick_edge(1);
        pulse_clear();
        repeat (3) tick_edge(2);
        check("clr_in_run", {8'd0, digits}, 32'h000008);

        // 5: simultaneous events
        sw.clk10ms    = 1'b1;
        sw.start_stop = 1'b1;
        step();
        sw.clk10ms    = 1'b0;
        sw.start_stop = 1'b0;
        step();
        check("ss_tick", {8'd0, digits}, 32'h000009);
        check("ss_tick_run", {31'd0, sw.running}, 32'd0);
        sw.start_stop = 1'b1;
        sw.clear      = 1'b1;
        step();
        sw.start_stop = 1'b0;
        sw.clear      = 1'b0;
        step();
        check("ss_clr", {8'd0, digits}, 32'h000000);
        check("ss_clr_run", {31'd0, sw.running}, 32'd0);

        // 6: held timebase gives one increment; async reset mid-run
        pulse_ss();
        sw.clk10ms = 1'b1;
        repeat (1000) step();
        sw.clk10ms = 1'b0;
        step();
        check("held_high", {8'd0, digits}, 32'h000001);
        repeat (3) tick_edge(1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_digits",  {8'd0, digits}, 32'd0);
        check("async_running", {31'd0, sw.running}, 32'd0);
        step();
        rst = 1'b1;
        step();

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            sw.clk10ms    = 1'($urandom_range(0, 1));
            sw.start_stop = ($urandom_range(0, 15) == 0);
            sw.clear      = ($urandom_range(0, 15) == 0);
            step();
        end
        sw.clk10ms    = 1'b0;
        sw.start_stop = 1'b0;
        sw.clear      = 1'b0;
        step();

        // 4: wrap at 01:59.99
        if (m_run) pulse_ss();
        pulse_clear();
        pulse_ss();
        repeat (MAX_CS) tick_edge(1);
        check("at_max", {8'd0, digits}, 32'h015999);
        check("at_max_wrap", {31'd0, sw.wrap}, 32'd0);
        sw.clk10ms = 1'b1;
        step();
        check("wrap_pulse",  {31'd0, sw.wrap}, 32'd1);
        check("wrap_digits", {8'd0, digits}, 32'h000000);
        check("wrap_run",    {31'd0, sw.running}, 32'd1);
        sw.clk10ms = 1'b0;
        step();
        check("wrap_end", {31'd0, sw.wrap}, 32'd0);
        tick_edge(1);
        check("after_wrap", {8'd0, digits}, 32'h000001);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_m_stopwatch_core
